// File: rtl/pcileech_ft601_responder.sv
// pcileech_ft601_responder
// Device-side model of the FT601 USB3 FIFO bridge in 245 synchronous 32-bit mode.
// Answers the FPGA-side pad signalling and exposes host-side streaming ports.
// Downstream FIFO (host->FPGA) and upstream FIFO (FPGA->host), each with burst/gap
// pacing of its ready flag.
// Build option: define PCILEECH_FT601_RESP_ERRCHK_EN to implement the sticky
// protocol error flags; otherwise the three error outputs are tied low.
module pcileech_ft601_responder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RX_BURST   = 8,
  parameter int unsigned TX_BURST   = 8,
  parameter int unsigned GAP_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ft601_oe_n,
  input  logic        ft601_rd_n,
  input  logic        ft601_wr_n,
  input  logic        ft601_siwu_n,
  input  logic [31:0] ft601_data_i,
  input  logic [3:0]  ft601_be_i,
  output logic [31:0] ft601_data_o,
  output logic [3:0]  ft601_be_o,
  output logic        ft601_data_oe,
  output logic        ft601_rxf_n,
  output logic        ft601_txe_n,
  input  logic [31:0] dn_data,
  input  logic        dn_valid,
  output logic        dn_ready,
  output logic [31:0] up_data,
  output logic [3:0]  up_be,
  output logic        up_valid,
  input  logic        up_ready,
  output logic        err_rd_underflow,
  output logic        err_wr_overflow,
  output logic        err_rd_no_oe
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned RBW = $clog2(RX_BURST + 1);
  localparam int unsigned TBW = $clog2(TX_BURST + 1);
  localparam int unsigned GW  = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [RBW-1:0] RX_LIM   = RBW'(RX_BURST);
  localparam logic [TBW-1:0] TX_LIM   = TBW'(TX_BURST);
  localparam logic [GW-1:0]  GAP_INIT = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} burst_state_t;

  // SIWU has no function in this model.
  logic w_unused;
  assign w_unused = ft601_siwu_n;

  // Registered flags
  logic r_rxf_n, r_txe_n, r_dn_ready, r_up_valid;

  // Downstream FIFO storage
  logic [31:0]   r_dn_mem [DEPTH];
  logic [AW-1:0] r_dn_wptr, r_dn_rptr;
  logic [CW-1:0] r_dn_count, w_dn_count_next;
  logic          w_dn_push, w_dn_pop;

  // Upstream FIFO storage: {be, data}
  logic [35:0]   r_up_mem [DEPTH];
  logic [AW-1:0] r_up_wptr, r_up_rptr;
  logic [CW-1:0] r_up_count, w_up_count_next;
  logic          w_up_push, w_up_pop;

  // Pacing FSMs
  burst_state_t   r_rx_state, w_rx_state_next;
  burst_state_t   r_tx_state, w_tx_state_next;
  logic [RBW-1:0] r_rx_cnt, w_rx_cnt_next, w_rx_cnt_inc;
  logic [TBW-1:0] r_tx_cnt, w_tx_cnt_next, w_tx_cnt_inc;
  logic [GW-1:0]  r_rx_gap, w_rx_gap_next;
  logic [GW-1:0]  r_tx_gap, w_tx_gap_next;

  assign w_dn_push = dn_valid & r_dn_ready;
  assign w_dn_pop  = ~ft601_oe_n & ~ft601_rd_n & ~r_rxf_n;
  assign w_up_push = ~ft601_wr_n & ~r_txe_n;
  assign w_up_pop  = r_up_valid & up_ready;

  assign w_rx_cnt_inc = r_rx_cnt + 1'b1;
  assign w_tx_cnt_inc = r_tx_cnt + 1'b1;

  // Output views; an empty FIFO presents zero rather than stale storage.
  assign ft601_data_o  = (r_dn_count != '0) ? r_dn_mem[r_dn_rptr] : '0;
  assign ft601_be_o    = '1;
  assign ft601_data_oe = ~ft601_oe_n;
  assign ft601_rxf_n   = r_rxf_n;
  assign ft601_txe_n   = r_txe_n;
  assign dn_ready      = r_dn_ready;
  assign up_valid      = r_up_valid;
  assign up_data       = r_up_valid ? r_up_mem[r_up_rptr][31:0]  : '0;
  assign up_be         = r_up_valid ? r_up_mem[r_up_rptr][35:32] : '0;

  // Next occupancy of both FIFOs
  always_comb begin
    w_dn_count_next = r_dn_count;
    w_up_count_next = r_up_count;
    if (w_dn_push & ~w_dn_pop)      w_dn_count_next = r_dn_count + 1'b1;
    else if (~w_dn_push & w_dn_pop) w_dn_count_next = r_dn_count - 1'b1;
    if (w_up_push & ~w_up_pop)      w_up_count_next = r_up_count + 1'b1;
    else if (~w_up_push & w_up_pop) w_up_count_next = r_up_count - 1'b1;
  end

  // FIFO storage writes (no reset needed; reads are gated by occupancy)
  always_ff @(posedge clk) begin
    if (w_dn_push) r_dn_mem[r_dn_wptr] <= dn_data;
    if (w_up_push) r_up_mem[r_up_wptr] <= {ft601_be_i, ft601_data_i};
  end

  // FIFO pointers and counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dn_wptr  <= '0;
      r_dn_rptr  <= '0;
      r_dn_count <= '0;
      r_up_wptr  <= '0;
      r_up_rptr  <= '0;
      r_up_count <= '0;
    end else begin
      if (w_dn_push) r_dn_wptr <= r_dn_wptr + 1'b1;
      if (w_dn_pop)  r_dn_rptr <= r_dn_rptr + 1'b1;
      if (w_up_push) r_up_wptr <= r_up_wptr + 1'b1;
      if (w_up_pop)  r_up_rptr <= r_up_rptr + 1'b1;
      r_dn_count <= w_dn_count_next;
      r_up_count <= w_up_count_next;
    end
  end

  // Read-side pacing: a burst ends on strobe release or on reaching the limit
  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt;
    w_rx_gap_next   = r_rx_gap;
    case (r_rx_state)
      ST_IDLE, ST_BURST: begin
        if ((r_rx_state == ST_BURST) && ft601_rd_n) begin
          w_rx_state_next = ST_IDLE;
          w_rx_cnt_next   = '0;
        end else if (w_dn_pop) begin
          if (w_rx_cnt_inc == RX_LIM) begin
            w_rx_state_next = ST_GAP;
            w_rx_cnt_next   = '0;
            w_rx_gap_next   = GAP_INIT;
          end else begin
            w_rx_state_next = ST_BURST;
            w_rx_cnt_next   = w_rx_cnt_inc;
          end
        end
      end
      ST_GAP: begin
        if (r_rx_gap == '0) w_rx_state_next = ST_IDLE;
        else                w_rx_gap_next   = r_rx_gap - 1'b1;
      end
      default: begin
        w_rx_state_next = ST_IDLE;
        w_rx_cnt_next   = '0;
        w_rx_gap_next   = '0;
      end
    endcase
  end

  // Write-side pacing, same rules keyed on the write strobe
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt;
    w_tx_gap_next   = r_tx_gap;
    case (r_tx_state)
      ST_IDLE, ST_BURST: begin
        if ((r_tx_state == ST_BURST) && ft601_wr_n) begin
          w_tx_state_next = ST_IDLE;
          w_tx_cnt_next   = '0;
        end else if (w_up_push) begin
          if (w_tx_cnt_inc == TX_LIM) begin
            w_tx_state_next = ST_GAP;
            w_tx_cnt_next   = '0;
            w_tx_gap_next   = GAP_INIT;
          end else begin
            w_tx_state_next = ST_BURST;
            w_tx_cnt_next   = w_tx_cnt_inc;
          end
        end
      end
      ST_GAP: begin
        if (r_tx_gap == '0) w_tx_state_next = ST_IDLE;
        else                w_tx_gap_next   = r_tx_gap - 1'b1;
      end
      default: begin
        w_tx_state_next = ST_IDLE;
        w_tx_cnt_next   = '0;
        w_tx_gap_next   = '0;
      end
    endcase
  end

  // FSM state registers and flags derived from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= ST_IDLE;
      r_tx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_tx_cnt   <= '0;
      r_rx_gap   <= '0;
      r_tx_gap   <= '0;
      r_rxf_n    <= 1'b1;
      r_txe_n    <= 1'b1;
      r_dn_ready <= 1'b0;
      r_up_valid <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_next;
      r_tx_state <= w_tx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_rx_gap   <= w_rx_gap_next;
      r_tx_gap   <= w_tx_gap_next;
      r_rxf_n    <= (w_dn_count_next == '0) | (w_rx_state_next == ST_GAP);
      r_txe_n    <= (w_up_count_next == FULL_CNT) | (w_tx_state_next == ST_GAP);
      r_dn_ready <= (w_dn_count_next != FULL_CNT);
      r_up_valid <= (w_up_count_next != '0);
    end
  end

`ifdef PCILEECH_FT601_RESP_ERRCHK_EN
  logic r_err_rd_underflow, r_err_wr_overflow, r_err_rd_no_oe;

  // Sticky protocol error capture, judged against the registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_rd_underflow <= 1'b0;
      r_err_wr_overflow  <= 1'b0;
      r_err_rd_no_oe     <= 1'b0;
    end else begin
      if (~ft601_rd_n & ~ft601_oe_n & r_rxf_n) r_err_rd_underflow <= 1'b1;
      if (~ft601_wr_n & r_txe_n)               r_err_wr_overflow  <= 1'b1;
      if (~ft601_rd_n & ft601_oe_n)            r_err_rd_no_oe     <= 1'b1;
    end
  end

  assign err_rd_underflow = r_err_rd_underflow;
  assign err_wr_overflow  = r_err_wr_overflow;
  assign err_rd_no_oe     = r_err_rd_no_oe;
`else
  assign err_rd_underflow = 1'b0;
  assign err_wr_overflow  = 1'b0;
  assign err_rd_no_oe     = 1'b0;
`endif

endmodule

// File: tb/tb_pcileech_ft601_responder.sv
// Testbench for pcileech_ft601_responder: directed table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pcileech_ft601_responder;

  localparam int unsigned DEPTH      = 16;
  localparam int unsigned RX_BURST   = 8;
  localparam int unsigned TX_BURST   = 8;
  localparam int unsigned GAP_CYCLES = 3;

`ifdef PCILEECH_FT601_RESP_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ft601_oe_n, ft601_rd_n, ft601_wr_n, ft601_siwu_n;
  logic [31:0] ft601_data_i;
  logic [3:0]  ft601_be_i;
  logic [31:0] ft601_data_o;
  logic [3:0]  ft601_be_o;
  logic        ft601_data_oe, ft601_rxf_n, ft601_txe_n;
  logic [31:0] dn_data;
  logic        dn_valid, dn_ready;
  logic [31:0] up_data;
  logic [3:0]  up_be;
  logic        up_valid, up_ready;
  logic        err_rd_underflow, err_wr_overflow, err_rd_no_oe;

  pcileech_ft601_responder #(
    .DEPTH(DEPTH), .RX_BURST(RX_BURST), .TX_BURST(TX_BURST), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ft601_oe_n(ft601_oe_n), .ft601_rd_n(ft601_rd_n), .ft601_wr_n(ft601_wr_n),
    .ft601_siwu_n(ft601_siwu_n), .ft601_data_i(ft601_data_i), .ft601_be_i(ft601_be_i),
    .ft601_data_o(ft601_data_o), .ft601_be_o(ft601_be_o), .ft601_data_oe(ft601_data_oe),
    .ft601_rxf_n(ft601_rxf_n), .ft601_txe_n(ft601_txe_n),
    .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready),
    .up_data(up_data), .up_be(up_be), .up_valid(up_valid), .up_ready(up_ready),
    .err_rd_underflow(err_rd_underflow), .err_wr_overflow(err_wr_overflow),
    .err_rd_no_oe(err_rd_no_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFOs as queues, pacing as "words in this burst" and
  // "gap cycles still to run".
  logic [31:0] m_dn[$];
  logic [35:0] m_up[$];
  logic m_rxf, m_txe, m_dn_ready, m_up_valid;
  logic m_e_under, m_e_over, m_e_nooe;
  int   m_rx_words, m_tx_words, m_rx_gap, m_tx_gap;

  typedef struct {
    logic        oe_n, rd_n, dn_valid;
    logic [31:0] dn_data;
    logic        exp_rxf_n, exp_dn_ready;
    logic [31:0] exp_data_o;
  } vec_t;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dn.delete();
    m_up.delete();
    m_rxf = 1'b1; m_txe = 1'b1; m_dn_ready = 1'b0; m_up_valid = 1'b0;
    m_e_under = 1'b0; m_e_over = 1'b0; m_e_nooe = 1'b0;
    m_rx_words = 0; m_tx_words = 0; m_rx_gap = 0; m_tx_gap = 0;
  endtask

  task automatic pace(input bit acc, input logic strobe_n, input int limit,
                      inout int words, inout int gap);
    if (gap > 0) gap--;
    else if (acc) begin
      words++;
      if (words == limit) begin
        words = 0;
        gap   = GAP_CYCLES;
      end
    end else if (strobe_n) words = 0;
  endtask

  task automatic model_step();
    bit rd_acc, wr_acc, push, pop;
    rd_acc = !ft601_oe_n && !ft601_rd_n && !m_rxf;
    wr_acc = !ft601_wr_n && !m_txe;
    push   = dn_valid && m_dn_ready;
    pop    = m_up_valid && up_ready;
    if (!ft601_rd_n && !ft601_oe_n && m_rxf) m_e_under = 1'b1;
    if (!ft601_wr_n && m_txe)                m_e_over  = 1'b1;
    if (!ft601_rd_n && ft601_oe_n)           m_e_nooe  = 1'b1;
    if (rd_acc) void'(m_dn.pop_front());
    if (push)   m_dn.push_back(dn_data);
    if (pop)    void'(m_up.pop_front());
    if (wr_acc) m_up.push_back({ft601_be_i, ft601_data_i});
    pace(rd_acc, ft601_rd_n, RX_BURST, m_rx_words, m_rx_gap);
    pace(wr_acc, ft601_wr_n, TX_BURST, m_tx_words, m_tx_gap);
    m_rxf      = (m_dn.size() == 0) || (m_rx_gap > 0);
    m_txe      = (m_up.size() == DEPTH) || (m_tx_gap > 0);
    m_dn_ready = (m_dn.size() != DEPTH);
    m_up_valid = (m_up.size() != 0);
  endtask

  task automatic check_all();
    logic [31:0] e_dn, e_upd;
    logic [3:0]  e_upb;
    e_dn  = (m_dn.size() != 0) ? m_dn[0] : 32'h0;
    e_upd = (m_up.size() != 0) ? m_up[0][31:0] : 32'h0;
    e_upb = (m_up.size() != 0) ? m_up[0][35:32] : 4'h0;
    chk("rxf_n", 36'(ft601_rxf_n), 36'(m_rxf));
    chk("txe_n", 36'(ft601_txe_n), 36'(m_txe));
    chk("dn_ready", 36'(dn_ready), 36'(m_dn_ready));
    chk("up_valid", 36'(up_valid), 36'(m_up_valid));
    chk("data_o", 36'(ft601_data_o), 36'(e_dn));
    chk("up_data", 36'(up_data), 36'(e_upd));
    chk("up_be", 36'(up_be), 36'(e_upb));
    chk("be_o", 36'(ft601_be_o), 36'(4'hF));
    chk("data_oe", 36'(ft601_data_oe), 36'(!ft601_oe_n));
    chk("err_under", 36'(err_rd_underflow), 36'(ERRCHK & m_e_under));
    chk("err_over", 36'(err_wr_overflow), 36'(ERRCHK & m_e_over));
    chk("err_nooe", 36'(err_rd_no_oe), 36'(ERRCHK & m_e_nooe));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_idle();
    ft601_oe_n = 1'b1; ft601_rd_n = 1'b1; ft601_wr_n = 1'b1; ft601_siwu_n = 1'b1;
    ft601_data_i = '0; ft601_be_i = '0;
    dn_valid = 1'b0; dn_data = '0; up_ready = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      dn_valid = 1'b1;
      dn_data  = base + 32'(i);
      tick();
    end
    dn_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    int   got;
    int   writes;
    bit   acc;

    // Directed table: three pushes then a three-word read (OE before RD).
    vt[0] = '{1, 1, 1, 32'hA0, 0, 1, 32'hA0};
    vt[1] = '{1, 1, 1, 32'hA1, 0, 1, 32'hA0};
    vt[2] = '{1, 1, 1, 32'hA2, 0, 1, 32'hA0};
    vt[3] = '{0, 1, 0, 32'h00, 0, 1, 32'hA0};
    vt[4] = '{0, 0, 0, 32'h00, 0, 1, 32'hA1};
    vt[5] = '{0, 0, 0, 32'h00, 0, 1, 32'hA2};
    vt[6] = '{0, 0, 0, 32'h00, 1, 1, 32'h00};
    vt[7] = '{1, 1, 0, 32'h00, 1, 1, 32'h00};

    do_reset();
    tick();
    chk("post_reset_txe", 36'(ft601_txe_n), 36'(0));
    chk("post_reset_ready", 36'(dn_ready), 36'(1));
    for (int i = 0; i < 8; i++) begin
      ft601_oe_n = vt[i].oe_n;
      ft601_rd_n = vt[i].rd_n;
      dn_valid   = vt[i].dn_valid;
      dn_data    = vt[i].dn_data;
      tick();
      chk("tbl_rxf_n", 36'(ft601_rxf_n), 36'(vt[i].exp_rxf_n));
      chk("tbl_ready", 36'(dn_ready), 36'(vt[i].exp_dn_ready));
      chk("tbl_data_o", 36'(ft601_data_o), 36'(vt[i].exp_data_o));
    end
    chk("tbl_no_err", 36'({err_rd_underflow, err_wr_overflow, err_rd_no_oe}), 36'(0));

    // Burst limit and gap on the read side.
    do_reset();
    tick();
    push_words(12, 32'hB00);
    ft601_oe_n = 1'b0;
    ft601_rd_n = 1'b0;
    got = 0;
    for (int i = 0; i < 15; i++) begin
      acc = !ft601_rxf_n;
      chk("burst_accept", 36'(acc), 36'((i < 8) || (i >= 11)));
      if (acc) begin
        chk("burst_data", 36'(ft601_data_o), 36'(32'hB00 + 32'(got)));
        got++;
      end
      tick();
    end
    set_idle();
    tick();
    chk("burst_total", 36'(got), 36'(12));

    // Upstream fill to full, overflow attempt, then drain.
    do_reset();
    tick();
    writes = 0;
    ft601_be_i = 4'h3;
    for (int c = 0; c < 60 && writes < 16; c++) begin
      if (!ft601_txe_n) begin
        ft601_wr_n   = 1'b0;
        ft601_data_i = 32'(writes);
        writes++;
      end else ft601_wr_n = 1'b1;
      tick();
    end
    ft601_wr_n = 1'b1;
    chk("ovf_writes", 36'(writes), 36'(16));
    chk("ovf_txe_full", 36'(ft601_txe_n), 36'(1));
    ft601_wr_n   = 1'b0;
    ft601_data_i = 32'hDEAD;
    tick();
    ft601_wr_n = 1'b1;
    chk("ovf_err", 36'(err_wr_overflow), 36'(ERRCHK));
    chk("ovf_head_data", 36'(up_data), 36'(0));
    chk("ovf_head_be", 36'(up_be), 36'(4'h3));
    up_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && up_valid; i++) begin
      chk("drain_data", 36'(up_data), 36'(i));
      got++;
      tick();
    end
    up_ready = 1'b0;
    chk("drain_count", 36'(got), 36'(16));
    tick();

    // Read strobe without output enable.
    do_reset();
    tick();
    push_words(2, 32'hC0);
    ft601_rd_n = 1'b0;
    tick();
    ft601_rd_n = 1'b1;
    chk("nooe_err", 36'(err_rd_no_oe), 36'(ERRCHK));
    chk("nooe_head", 36'(ft601_data_o), 36'(32'hC0));
    tick();

    // Read on an empty FIFO.
    do_reset();
    tick();
    ft601_oe_n = 1'b0;
    ft601_rd_n = 1'b0;
    tick();
    set_idle();
    chk("under_err", 36'(err_rd_underflow), 36'(ERRCHK));
    tick();

    // Asynchronous reset in the middle of a read burst.
    do_reset();
    tick();
    push_words(5, 32'hD0);
    ft601_oe_n = 1'b0;
    ft601_rd_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_rxf", 36'(ft601_rxf_n), 36'(1));
    chk("arst_txe", 36'(ft601_txe_n), 36'(1));
    chk("arst_ready", 36'(dn_ready), 36'(0));
    chk("arst_valid", 36'(up_valid), 36'(0));
    chk("arst_data_o", 36'(ft601_data_o), 36'(0));
    chk("arst_oe", 36'(ft601_data_oe), 36'(1));
    set_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    tick();
    chk("arst_rel_rxf", 36'(ft601_rxf_n), 36'(1));
    chk("arst_rel_txe", 36'(ft601_txe_n), 36'(0));

    // Randomized traffic against the reference model.
    do_reset();
    tick();
    for (int i = 0; i < 3000; i++) begin
      ft601_oe_n   = ($urandom_range(0, 3) == 0);
      ft601_rd_n   = ($urandom_range(0, 2) == 0);
      ft601_wr_n   = ($urandom_range(0, 2) == 0);
      ft601_siwu_n = 1'($urandom);
      ft601_data_i = $urandom;
      ft601_be_i   = 4'($urandom);
      dn_valid     = ($urandom_range(0, 2) != 0);
      dn_data      = $urandom;
      up_ready     = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
